// File: rtl/rf_write_scheduler.sv
// Register-file write scheduler: zero-fills every entry after reset, then
// round-robin arbitrates two write requesters onto a single registered write port.
`timescale 1ns/1ps
module rf_write_scheduler #(
   parameter int unsigned raw      = 5,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           a_valid_i,
   input  logic [raw-1:0] a_addr_i,
   input  logic [31:0]    a_data_i,
   output logic           a_ready_o,
   input  logic           b_valid_i,
   input  logic [raw-1:0] b_addr_i,
   input  logic [31:0]    b_data_i,
   output logic           b_ready_o,
   output logic [raw-1:0] rf_rd_addr_o,
   output logic           rf_wen_o,
   output logic [31:0]    rf_write_data_o,
   output logic           busy_o,
   output logic [15:0]    stall_cnt_o
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   // Handshake: a write transfers on a rising edge where valid and ready are
   // both high; ready depends on valid, never the reverse, and refused
   // requesters hold valid/addr/data until they see ready.
   state_t           state_q, state_d;
   logic [raw-1:0]   clr_cnt_q, clr_cnt_d;
   logic             last_b_q, last_b_d;
   logic             wen_q, wen_d;
   logic [raw-1:0]   addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   logic [15:0]      stall_q, stall_d;
   logic             grant_a, grant_b;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      last_b_d  = last_b_q;
      wen_d     = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      stall_d   = stall_q;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            wen_d     = 1'b1;
            addr_d    = clr_cnt_q;
            data_d    = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) state_d = ST_RUN;
         end
         default: begin
            // On a tie the requester that did not win last time goes first.
            if (a_valid_i && b_valid_i) begin
               grant_a = last_b_q;
               grant_b = !last_b_q;
            end else begin
               grant_a = a_valid_i;
               grant_b = b_valid_i;
            end
            if (grant_a) begin
               addr_d = a_addr_i;
               data_d = a_data_i;
            end else if (grant_b) begin
               addr_d = b_addr_i;
               data_d = b_data_i;
            end
            // Address 0 is hardwired when ZERO_REG is set: accept, but never write it.
            wen_d = (grant_a || grant_b) && !(ZERO_REG && (addr_d == '0));
            if (grant_a || grant_b) last_b_d = grant_b;
            if (((a_valid_i && !grant_a) || (b_valid_i && !grant_b)) && (stall_q != 16'hFFFF))
               stall_d = stall_q + 16'd1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         last_b_q  <= 1'b1;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         stall_q   <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         last_b_q  <= last_b_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         stall_q   <= stall_d;
      end
   end

   assign a_ready_o       = grant_a;
   assign b_ready_o       = grant_b;
   assign busy_o          = (state_q == ST_CLEAR);
   assign rf_wen_o        = wen_q;
   assign rf_rd_addr_o    = addr_q;
   assign rf_write_data_o = data_q;
   assign stall_cnt_o     = stall_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Randomised scoreboard bench for rf_write_scheduler: a behavioural model predicts
// readies, busy and stall count per cycle and queues the writes the port must show.
`timescale 1ns/1ps
module tb_rf_write_scheduler;

   localparam int RAW   = 5;
   localparam int DEPTH = 1 << RAW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           a_valid_i = 1'b0, b_valid_i = 1'b0;
   logic [RAW-1:0] a_addr_i = '0, b_addr_i = '0;
   logic [31:0]    a_data_i = '0, b_data_i = '0;
   logic           a_ready_o, b_ready_o, rf_wen_o, busy_o;
   logic [RAW-1:0] rf_rd_addr_o;
   logic [31:0]    rf_write_data_o;
   logic [15:0]    stall_cnt_o;

   rf_write_scheduler #(.raw(RAW), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst(rst),
      .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
      .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
      .rf_rd_addr_o(rf_rd_addr_o), .rf_wen_o(rf_wen_o), .rf_write_data_o(rf_write_data_o),
      .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [RAW+31:0] exp_q[$];

   // Reference model state
   bit m_known  = 1'b0;
   bit m_clear  = 1'b1;
   int m_idx    = 0;
   bit m_last_b = 1'b1;
   int m_stall  = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // One cycle: drive on the falling edge, check combinational outputs against
   // the model, then advance the model to the state after the next rising edge.
   task automatic step(input bit r, input bit av, input logic [RAW-1:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [RAW-1:0] ba, input logic [31:0] bd,
                       output bit ga, output bit gb);
      @(negedge clk);
      rst = r; a_valid_i = av; a_addr_i = aa; a_data_i = ad;
      b_valid_i = bv; b_addr_i = ba; b_data_i = bd;
      #1;
      ga = 1'b0;
      gb = 1'b0;
      if (m_known) begin
         if (!m_clear) begin
            if (av && bv) begin
               ga = m_last_b;
               gb = !m_last_b;
            end else begin
               ga = av;
               gb = bv;
            end
         end
         chk("busy", 32'(busy_o), 32'(m_clear));
         chk("a_ready", 32'(a_ready_o), 32'(ga));
         chk("b_ready", 32'(b_ready_o), 32'(gb));
         chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
      end
      if (r) begin
         m_known = 1'b1; m_clear = 1'b1; m_idx = 0; m_last_b = 1'b1; m_stall = 0;
         ga = 1'b0; gb = 1'b0;
      end else if (m_clear) begin
         exp_q.push_back({RAW'(m_idx), 32'h0});
         m_idx++;
         if (m_idx == DEPTH) m_clear = 1'b0;
      end else begin
         if (ga && aa != 0) exp_q.push_back({aa, ad});
         if (gb && ba != 0) exp_q.push_back({ba, bd});
         if (ga || gb) m_last_b = gb;
         if (((av && !ga) || (bv && !gb)) && m_stall < 16'hFFFF) m_stall++;
      end
   endtask

   // Monitor: every enabled write must match the head of the expected queue,
   // and every queued write must appear at the following edge.
   always @(negedge clk) begin
      logic [RAW+31:0] e;
      if (rf_wen_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got addr %0h data %0h expected no write at %0t",
                     rf_rd_addr_o, rf_write_data_o, $time);
         end else begin
            e = exp_q.pop_front();
            if ({rf_rd_addr_o, rf_write_data_o} !== e) begin
               errors++;
               $display("FAIL wr_data: got addr %0h data %0h expected addr %0h data %0h at %0t",
                        rf_rd_addr_o, rf_write_data_o, e[RAW+31:32], e[31:0], $time);
            end
         end
      end else if (exp_q.size() != 0) begin
         checks++;
         errors++;
         e = exp_q.pop_front();
         $display("FAIL wr_missing: got wen %b expected write addr %0h data %0h at %0t",
                  rf_wen_o, e[RAW+31:32], e[31:0], $time);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish by 2ms");
      $fatal(1, "timeout");
   end

   initial begin
      bit ga, gb;
      bit pa_v, pb_v;
      logic [RAW-1:0] pa_addr, pb_addr;
      logic [31:0] pa_data, pb_data;
      int s0;

      // Reset and post-reset register state
      step(1, 0, '0, '0, 0, '0, '0, ga, gb);
      step(1, 0, '0, '0, 0, '0, '0, ga, gb);
      @(posedge clk); #1;
      chk("rst_wen", 32'(rf_wen_o), 32'd0);
      chk("rst_addr", 32'(rf_rd_addr_o), 32'd0);
      chk("rst_data", rf_write_data_o, 32'd0);
      chk("rst_stall", 32'(stall_cnt_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd1);

      // Full clear sequence, then one idle RUN cycle
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, '0, '0, 0, '0, '0, ga, gb);

      // Single A write
      step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, ga, gb);
      step(0, 0, '0, '0, 0, '0, '0, ga, gb);

      // Tie for 4 cycles: alternating grants, one stall per cycle
      s0 = m_stall;
      for (int i = 0; i < 4; i++) step(0, 1, 5'd1, $urandom, 1, 5'd2, $urandom, ga, gb);
      @(posedge clk); #1;
      chk("tie_stall", 32'(stall_cnt_o), 32'(s0 + 4));

      // B writes the hardwired zero register: accepted, registered, not enabled
      step(0, 0, '0, '0, 1, 5'd0, 32'd7, ga, gb);
      @(posedge clk); #1;
      chk("zero_addr", 32'(rf_rd_addr_o), 32'd0);
      chk("zero_data", rf_write_data_o, 32'd7);
      chk("zero_wen", 32'(rf_wen_o), 32'd0);

      // Random traffic with refused requesters holding their request
      pa_v = 0; pb_v = 0; pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pa_v && $urandom_range(0, 2) != 0) begin
            pa_v = 1; pa_addr = RAW'($urandom_range(0, DEPTH - 1)); pa_data = $urandom;
         end
         if (!pb_v && $urandom_range(0, 2) != 0) begin
            pb_v = 1; pb_addr = RAW'($urandom_range(0, DEPTH - 1)); pb_data = $urandom;
         end
         step(0, pa_v, pa_addr, pa_data, pb_v, pb_addr, pb_data, ga, gb);
         if (ga) pa_v = 0;
         if (gb) pb_v = 0;
      end

      // Drive the stall counter to saturation with continuous ties
      while (m_stall < 16'hFFFE)
         step(0, 1, RAW'($urandom_range(1, DEPTH - 1)), $urandom, 1, RAW'($urandom_range(1, DEPTH - 1)), $urandom, ga, gb);
      for (int i = 0; i < 3; i++) step(0, 1, 5'd3, $urandom, 1, 5'd4, $urandom, ga, gb);
      @(posedge clk); #1;
      chk("stall_sat", 32'(stall_cnt_o), 32'hFFFF);
      for (int i = 0; i < 2; i++) step(0, 1, 5'd3, $urandom, 1, 5'd4, $urandom, ga, gb);

      // Reset with a grant pending in RUN (write dropped), then reset mid-clear
      step(1, 1, 5'd6, 32'hA5A5A5A5, 0, '0, '0, ga, gb);
      step(1, 0, '0, '0, 0, '0, '0, ga, gb);
      for (int i = 0; i < 10; i++) step(0, 1, 5'd9, 32'h1234, 0, '0, '0, ga, gb);
      step(1, 1, 5'd9, 32'h1234, 0, '0, '0, ga, gb);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 5'd9, 32'h1234, 0, '0, '0, ga, gb);
      step(0, 1, 5'd9, 32'h1234, 0, '0, '0, ga, gb);
      chk("post_clear_grant", 32'(ga), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, '0, '0, ga, gb);

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
